// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the HI/LO multiply/divide resource
// (MULT/MULTU/DIV/DIVU). Latches one operation, runs a fixed-latency
// multiply or a 32-step restoring divide, stalls the pipeline while busy,
// then raises hilo_we for one cycle with hi/lo already holding the result.
//
// Optional build macro:
//   MUL_DIV_ZERO_EARLY_EN - a divide whose latched divisor is zero skips the
//   iterations and reaches DONE after a single DIV cycle. The result is the
//   same as the full iterative path.
//
// Handshake: start is a single-cycle request qualified by the pipeline; it
// is taken only in IDLE without flush. stall is combinational and covers the
// accept cycle plus every MUL/DIV cycle; hilo_we is the only completion
// signal and is never raised for a flushed operation.

module muldiv_ctrl #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_div,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Operand sign handling shared by multiply and divide.
    logic        a_neg, b_neg;
    logic [31:0] b_mag;
    logic [31:0] in_a_mag;
    logic [63:0] ext_a, ext_b, prod;

    // One restoring-division step on the current partial remainder.
    logic [32:0] step_t;
    logic [32:0] step_diff;
    logic        step_ge;
    logic [31:0] step_rem;
    logic [31:0] step_quo;

    // Signed fix-up: quotient negated when operand signs differ, remainder
    // takes the dividend's sign. Returns {hi, lo}.
    function automatic logic [63:0] fixup(input logic [31:0] q_mag,
                                          input logic [31:0] r_mag,
                                          input logic        q_neg,
                                          input logic        r_neg);
        logic [31:0] q_o;
        logic [31:0] r_o;
        q_o = q_neg ? (32'd0 - q_mag) : q_mag;
        r_o = r_neg ? (32'd0 - r_mag) : r_mag;
        return {r_o, q_o};
    endfunction

    // Magnitudes, sign extensions, product and divide step from latched operands.
    always_comb begin
        a_neg     = sgn_q & a_q[31];
        b_neg     = sgn_q & b_q[31];
        b_mag     = b_neg ? (32'd0 - b_q) : b_q;
        in_a_mag  = (is_signed & a[31]) ? (32'd0 - a) : a;
        ext_a     = {{32{a_neg}}, a_q};
        ext_b     = {{32{b_neg}}, b_q};
        prod      = ext_a * ext_b;
        step_t    = {rem_q, quo_q[31]};
        step_diff = step_t - {1'b0, b_mag};
        step_ge   = ~step_diff[32];
        step_rem  = step_ge ? step_diff[31:0] : step_t[31:0];
        step_quo  = {quo_q[30:0], step_ge};
    end

`ifdef MUL_DIV_ZERO_EARLY_EN
    logic [31:0] a_mag;

    // Dividend magnitude for the zero-divisor shortcut result.
    always_comb begin
        a_mag = a_neg ? (32'd0 - a_q) : a_q;
    end
`endif

    // Next-state, operand latch, divide datapath and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = is_signed;
                    cnt_d   = 6'd1;
                    rem_d   = 32'd0;
                    quo_d   = in_a_mag;
                    state_d = is_div ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                if (cnt_q == 6'(MUL_LAT)) begin
                    state_d = S_DONE;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DIV: begin
`ifdef MUL_DIV_ZERO_EARLY_EN
                if (b_q == 32'd0) begin
                    state_d      = S_DONE;
                    {hi_d, lo_d} = fixup(32'hFFFF_FFFF, a_mag, a_neg ^ b_neg, a_neg);
                end else
`endif
                begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == 6'(DIV_ITER)) begin
                        state_d      = S_DONE;
                        {hi_d, lo_d} = fixup(step_quo, step_rem, a_neg ^ b_neg, a_neg);
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush abandons whatever is in flight and must not disturb hi/lo.
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Pipeline-facing status; stall covers the accept cycle and drops on flush.
    always_comb begin
        busy    = (state_q == S_MUL) || (state_q == S_DIV);
        stall   = !flush && (((state_q == S_IDLE) && start) || busy);
        hilo_we = (state_q == S_DONE) && !flush;
        hi      = hi_q;
        lo      = lo_q;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed and randomized checks of muldiv_ctrl against a plain-arithmetic
// reference of the HI/LO multiply/divide results and cycle timing.
// Honours MUL_DIV_ZERO_EARLY_EN for the divide-by-zero latency.

module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_div;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_pass  = 0;
    int n_total = 0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_div    (is_div),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .hilo_we   (hilo_we),
        .hi        (hi),
        .lo        (lo)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} from the architectural definition.
    function automatic logic [63:0] ref_result(input logic d, input logic s,
                                               input logic [31:0] ra, input logic [31:0] rb);
        logic [63:0] p;
        logic [31:0] am, bm, q, r;
        if (!d) begin
            if (s) p = 64'(longint'($signed(ra)) * longint'($signed(rb)));
            else   p = {32'd0, ra} * {32'd0, rb};
            return p;
        end
        am = (s && ra[31]) ? (32'd0 - ra) : ra;
        bm = (s && rb[31]) ? (32'd0 - rb) : rb;
        if (bm == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = am;
        end else begin
            q = am / bm;
            r = am % bm;
        end
        if (s && (ra[31] ^ rb[31])) q = 32'd0 - q;
        if (s && ra[31])            r = 32'd0 - r;
        return {r, q};
    endfunction

    function automatic int lat_of(input logic d, input logic [31:0] rb);
        if (!d) return MUL_LAT + 1;
`ifdef MUL_DIV_ZERO_EARLY_EN
        if (rb == 32'd0) return 2;
`endif
        return 33;
    endfunction

    // Driver: issue one op, follow it to hilo_we, check timing and result.
    // hold keeps start asserted (with junk operands) while busy.
    task automatic do_op(input string tag, input logic d, input logic s,
                         input logic [31:0] oa, input logic [31:0] ob, input logic hold);
        logic [63:0] exp;
        int          n;
        int          lat;
        logic        busy_ok;
        int          extra_we;
        exp      = ref_result(d, s, oa, ob);
        lat      = lat_of(d, ob);
        busy_ok  = 1'b1;
        extra_we = 0;
        start = 1'b1; is_div = d; is_signed = s; a = oa; b = ob;
        #1;
        check({tag, " accept_stall"}, stall, 1);
        check({tag, " accept_we"}, hilo_we, 0);
        tick();
        n = 1;
        if (!hold) start = 1'b0;
        else begin a = $urandom; b = $urandom; is_div = $urandom_range(0, 1); end
        #1;
        while (hilo_we !== 1'b1 && n < 100) begin
            if (stall !== 1'b1 || busy !== 1'b1) busy_ok = 1'b0;
            tick();
            if (hold) begin a = $urandom; b = $urandom; end
            #1;
            n++;
        end
        start = 1'b0;
        #1;
        check({tag, " busy_stall"}, busy_ok, 1);
        check({tag, " latency"}, n, lat);
        check({tag, " done_we"}, hilo_we, 1);
        check({tag, " done_stall"}, {stall, busy}, 0);
        check({tag, " hilo"}, {hi, lo}, exp);
        tick();
        #1;
        check({tag, " we_one_cycle"}, hilo_we, 0);
        if (hold) begin
            for (int i = 0; i < 40; i++) begin
                if (hilo_we === 1'b1 || busy === 1'b1) extra_we++;
                tick();
            end
            check({tag, " no_extra_op"}, extra_we, 0);
        end
    endtask

    initial begin
        logic [31:0] h0, l0;
        int          we_seen;
        logic        rd, rs;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; is_div = 1'b0; is_signed = 1'b0;
        a = 32'd0; b = 32'd0; flush = 1'b0;
        tick(); tick();
        check("reset_outputs", {stall, busy, hilo_we, hi, lo}, 0);
        rst = 1'b0;
        tick();
        check("idle_outputs", {stall, busy, hilo_we}, 0);

        // Directed cases with values worked from the definition.
        do_op("multu_ffff_x2", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu_vals", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        do_op("mult_m3_x7", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_vals", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("div_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_vals", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu_7_2", 1'b1, 1'b0, 32'd7, 32'd2, 1'b0);
        check("divu_vals", {hi, lo}, 64'h0000_0001_0000_0003);
        do_op("divu_by0", 1'b1, 1'b0, 32'h1234, 32'd0, 1'b0);
        check("divu_by0_vals", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        do_op("div_s_by0", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
        do_op("div_min_m1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_min_vals", {hi, lo}, 64'h0000_0000_8000_0000);

        // start with flush in IDLE is not accepted.
        start = 1'b1; flush = 1'b1; is_div = 1'b0; a = 32'd5; b = 32'd5;
        #1;
        check("start_flush_stall", stall, 0);
        tick();
        start = 1'b0; flush = 1'b0;
        #1;
        check("start_flush_not_busy", {busy, stall, hilo_we}, 0);

        // Flush a divide at T+10.
        h0 = hi; l0 = lo;
        start = 1'b1; is_div = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush = 1'b1;
        #1;
        check("flush_stall_drop", {stall, hilo_we}, 0);
        check("flush_busy_still", busy, 1);
        tick();
        flush = 1'b0;
        #1;
        check("flush_idle", {busy, stall}, 0);
        we_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (hilo_we === 1'b1) we_seen++;
            tick();
        end
        check("flush_no_we", we_seen, 0);
        check("flush_hilo_kept", {hi, lo}, {h0, l0});
        do_op("multu_after_flush", 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);

        // Asynchronous reset mid-divide.
        start = 1'b1; is_div = 1'b1; is_signed = 1'b0; a = 32'hFFFF_0000; b = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {stall, busy, hilo_we, hi, lo}, 0);
        tick();
        rst = 1'b0;
        we_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (hilo_we === 1'b1) we_seen++;
            tick();
        end
        check("rst_no_we", we_seen, 0);

        // start held while busy is ignored.
        do_op("hold_div", 1'b1, 1'b1, 32'd100, 32'hFFFF_FFF7, 1'b1);
        do_op("hold_mul", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);

        // Randomized operations against the reference.
        for (int k = 0; k < 24; k++) begin
            rd = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 17));
            do_op($sformatf("rand%0d", k), rd, rs, ra, rb, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
